// File: rtl/camerax_sweep_gen.sv
// Streams one camera-plane X coordinate per screen column. The values come from an
// exact quotient/remainder accumulator, so there is no lookup table and no divider.
module camerax_sweep_gen #(
    parameter int SCREEN_W = 320,
    parameter int FRAC_W   = 8,
    parameter int DATA_W   = 16,
    parameter int COL_W    = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [COL_W-1:0]  out_col,
    output logic [DATA_W-1:0] out_camerax,
    output logic              out_last
);
    // q spans [-2^FRAC_W, 2^FRAC_W). The remainder needs one extra bit to hold r + STEP_R.
    localparam int Q_W       = FRAC_W + 2;
    localparam int R_W       = $clog2(SCREEN_W) + 1;
    localparam int STEP_Q_I  = (2 ** (FRAC_W + 1)) / SCREEN_W;
    localparam int STEP_R_I  = (2 ** (FRAC_W + 1)) % SCREEN_W;

    localparam logic signed [Q_W-1:0] STEP_Q = Q_W'(STEP_Q_I);
    localparam logic signed [Q_W-1:0] Q_INIT = Q_W'(-(2 ** FRAC_W));
    localparam logic [R_W-1:0]        STEP_R = R_W'(STEP_R_I);
    localparam logic [R_W-1:0]        SW_R   = R_W'(SCREEN_W);
    localparam logic [COL_W-1:0]      LAST_X = COL_W'(SCREEN_W - 1);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_d;

    logic [COL_W-1:0]      x_q;
    logic signed [Q_W-1:0] q_q;
    logic [R_W-1:0]        r_q, r_sum;
    logic                  last_q, advance, wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // A start pulse takes priority over a transfer and always re-enters RUN at column 0.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (start) state_d = RUN;
            RUN:  if (!start && out_ready && last_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state == RUN);
        busy      = (state == RUN);
    end

    assign advance = (state == RUN) && out_ready && !start && !last_q;
    assign r_sum   = r_q + STEP_R;
    assign wrap    = (r_sum >= SW_R);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            q_q    <= '0;
            r_q    <= '0;
            last_q <= 1'b0;
        end else if (start) begin
            x_q    <= '0;
            q_q    <= Q_INIT;
            r_q    <= '0;
            last_q <= 1'b0;
        end else if (advance) begin
            x_q    <= x_q + COL_W'(1);
            last_q <= (x_q + COL_W'(1) == LAST_X);
            if (wrap) begin
                r_q <= r_sum - SW_R;
                q_q <= q_q + STEP_Q + Q_W'(1);
            end else begin
                r_q <= r_sum;
                q_q <= q_q + STEP_Q;
            end
        end
    end

    assign out_col     = x_q;
    assign out_last    = last_q;
    assign out_camerax = DATA_W'(q_q);

endmodule

// File: tb/tb_camerax_sweep_gen.sv
// Scoreboard bench for camerax_sweep_gen. It drives three instances with different geometries,
// and a floor-division model plus hand-computed vectors supply the expected beats.
module tb_camerax_sweep_gen;
    typedef struct {
        int     col;
        longint cx;
        bit     last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start1 = 0, ready1 = 0, busy1, valid1, last1;
    logic [8:0]  col1;
    logic [15:0] cx1;
    logic        start2 = 0, ready2 = 1, busy2, valid2, last2;
    logic [9:0]  col2;
    logic [19:0] cx2;
    logic        start3 = 0, ready3 = 1, busy3, valid3, last3;
    logic [0:0]  col3;
    logic [15:0] cx3;

    camerax_sweep_gen u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .out_valid(valid1),
        .out_ready(ready1), .out_col(col1), .out_camerax(cx1), .out_last(last1));

    camerax_sweep_gen #(.SCREEN_W(640), .FRAC_W(12), .DATA_W(20), .COL_W(10)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .out_valid(valid2),
        .out_ready(ready2), .out_col(col2), .out_camerax(cx2), .out_last(last2));

    camerax_sweep_gen #(.SCREEN_W(2), .FRAC_W(8), .DATA_W(16), .COL_W(1)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .busy(busy3), .out_valid(valid3),
        .out_ready(ready3), .out_col(col3), .out_camerax(cx3), .out_last(last3));

    int   checks = 0, failures = 0;
    int   xfers1 = 0, xfers2 = 0, xfers3 = 0;
    exp_t sb1[$], sb2[$], sb3[$];
    bit   first_sweep = 0;
    logic [15:0] spot[int];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic longint fcx(input int x, input int w, input int f);
        longint n, q;
        n = longint'(2 * x - w) * (longint'(1) << f);
        q = n / w;
        if ((n % w) != 0 && n < 0) q = q - 1;
        return q;
    endfunction

    task automatic push_sweep1();
        for (int x = 0; x < 320; x++) sb1.push_back('{x, fcx(x, 320, 8), x == 319});
    endtask

    task automatic push_sweep2();
        for (int x = 0; x < 640; x++) sb2.push_back('{x, fcx(x, 640, 12), x == 639});
    endtask

    // Monitor for the 320/8 instance: checks each transfer against the scoreboard and checks
    // that the outputs hold steady through a stall.
    bit          stall_p = 0, start_p = 0;
    logic [25:0] prev1;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_p = 0;
            start_p = 0;
        end else begin
            if (stall_p && !start_p) chk("stall_hold", {col1, cx1, last1}, prev1);
            if (start1) xfers1 = 0;
            if (valid1 && ready1 && !start1) begin
                if (sb1.size() == 0) begin
                    chk("sb1_unexpected_col", col1, -1);
                end else begin
                    exp_t e;
                    e = sb1.pop_front();
                    chk("beat1", {col1, cx1, last1}, {e.col[8:0], e.cx[15:0], e.last});
                    if (first_sweep && spot.exists(int'(col1)))
                        chk("spot_cx", cx1, spot[int'(col1)]);
                end
                xfers1++;
            end
            stall_p = valid1 && !ready1;
            start_p = start1;
            prev1   = {col1, cx1, last1};
        end
    end

    always @(negedge clk) begin
        if (rst_n && valid2 && ready2 && !start2) begin
            if (sb2.size() == 0) chk("sb2_unexpected_col", col2, -1);
            else begin
                exp_t e;
                e = sb2.pop_front();
                chk("beat2", {col2, cx2, last2}, {e.col[9:0], e.cx[19:0], e.last});
            end
            xfers2++;
        end
    end

    always @(negedge clk) begin
        if (rst_n && valid3 && ready3 && !start3) begin
            if (sb3.size() == 0) chk("sb3_unexpected_col", col3, -1);
            else begin
                exp_t e;
                e = sb3.pop_front();
                chk("beat3", {col3, cx3, last3}, {e.col[0:0], e.cx[15:0], e.last});
            end
            xfers3++;
        end
    end

    task automatic launch1();
        sb1.delete();
        push_sweep1();
        start1 = 1;
        @(posedge clk); #1;
        start1 = 0;
    endtask

    task automatic run_until_idle1(input bit rnd);
        int n = 0;
        while (busy1 && n < 5000) begin
            ready1 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            n++;
        end
        chk("idle1_timeout", busy1, 0);
        chk("sb1_drained", sb1.size(), 0);
        chk("xfers1", xfers1, 320);
    endtask

    task automatic seek_col1(input int c, input bit rnd);
        int n = 0;
        while (!(valid1 && col1 == 9'(c)) && n < 5000) begin
            ready1 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            n++;
        end
        chk("seek_timeout", n < 5000, 1);
    endtask

    task automatic abort_at_100(input bit with_xfer);
        ready1 = 0;
        launch1();
        seek_col1(100, 1);
        ready1 = with_xfer;
        start1 = 1;
        sb1.delete();
        push_sweep1();
        @(posedge clk); #1;
        start1 = 0;
        chk("abort_valid", valid1, 1);
        chk("abort_col", col1, 0);
        chk("abort_cx", cx1, 16'hFF00);
        run_until_idle1(1);
    endtask

    initial begin
        int n, bad;
        spot[0]   = 16'hFF00;
        spot[1]   = 16'hFF01;
        spot[2]   = 16'hFF03;
        spot[160] = 16'h0000;
        spot[319] = 16'h00FE;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", valid1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_col", col1, 0);
        chk("rst_cx", cx1, 0);
        chk("rst_last", last1, 0);
        rst_n = 1;
        @(posedge clk); #1;

        // Full sweep with the consumer always ready, plus the latency and end-of-sweep timing.
        ready1 = 1;
        first_sweep = 1;
        launch1();
        chk("lat_valid", valid1, 1);
        chk("lat_col", col1, 0);
        repeat (319) @(posedge clk);
        #1;
        chk("end_col", col1, 319);
        chk("end_last", last1, 1);
        chk("end_busy", busy1, 1);
        @(posedge clk); #1;
        chk("done_busy", busy1, 0);
        chk("done_valid", valid1, 0);
        chk("sb1_drained", sb1.size(), 0);
        chk("xfers1", xfers1, 320);
        first_sweep = 0;

        // Random back-pressure.
        ready1 = 0;
        launch1();
        run_until_idle1(1);

        abort_at_100(0);
        abort_at_100(1);

        // The wide instance and the minimum-width instance, with the consumer always ready.
        sb2.delete();
        push_sweep2();
        sb3.delete();
        sb3.push_back('{0, -256, 1'b0});
        sb3.push_back('{1, 0, 1'b1});
        start2 = 1;
        start3 = 1;
        @(posedge clk); #1;
        start2 = 0;
        start3 = 0;
        n = 0;
        while ((busy2 || busy3) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle2_timeout", busy2 | busy3, 0);
        chk("sb2_drained", sb2.size(), 0);
        chk("xfers2", xfers2, 640);
        chk("sb3_drained", sb3.size(), 0);
        chk("xfers3", xfers3, 2);

        // Reset in the middle of a sweep.
        ready1 = 1;
        launch1();
        seek_col1(50, 0);
        rst_n = 0;
        #1;
        chk("mrst_valid", valid1, 0);
        chk("mrst_busy", busy1, 0);
        chk("mrst_col", col1, 0);
        chk("mrst_cx", cx1, 0);
        chk("mrst_last", last1, 0);
        sb1.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            bad += int'(valid1 | busy1);
        end
        chk("post_rst_quiet", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/camerax_sweep_gen.md
Name: camerax_sweep_gen

Overview:
- Streaming generator of per-column camera-plane X coordinates for the raycaster front end.
- Replaces the fixed 320-entry Q8.8 lookup table with exact incremental arithmetic, so screen width and fraction width are parameters.
- Each frame it emits one signed fixed-point cameraX per screen column, in column order, over a valid/ready stream to the ray setup stage.
- Supports back-pressure and mid-frame restart.

Parameters:
- SCREEN_W, 320, number of screen columns; legal range 2..4095.
- FRAC_W, 8, fraction bits of the cameraX output.
- DATA_W, 16, total signed width of the cameraX output; must be at least FRAC_W+2.
- COL_W, 9, width of the column index; must satisfy 2^COL_W >= SCREEN_W.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins a new sweep at column 0; also restarts a sweep already in progress.
- busy  out  1  high from the cycle after start until the last column has been accepted.
- out_valid  out  1  out_col, out_camerax and out_last are valid.
- out_ready  in  1  consumer accepts the current output this cycle.
- out_col  out  COL_W  column index x of the current output.
- out_camerax  out  DATA_W  cameraX(x), signed, with FRAC_W fraction bits.
- out_last  out  1  high when out_col == SCREEN_W-1.

Behaviour:
- Arithmetic definition (exact; floor toward minus infinity): cameraX(x) = floor(((2x - SCREEN_W) * 2^FRAC_W) / SCREEN_W).
- Implementation uses a quotient/remainder accumulator (q, r) with 0 <= r < SCREEN_W.
  - Elaboration constants: STEP_Q = floor(2^(FRAC_W+1) / SCREEN_W) and STEP_R = 2^(FRAC_W+1) mod SCREEN_W.
  - Init at x=0: q = -2^FRAC_W, r = 0.
  - Advance: r' = r + STEP_R; if r' >= SCREEN_W then r = r' - SCREEN_W and q = q + STEP_Q + 1, else r = r' and q = q + STEP_Q.
  - No dividers and no table in the datapath.
  - The remainder register is ceil(log2(SCREEN_W)) bits plus 1 carry bit.
  - out_camerax is q sign-extended or truncated to DATA_W.
- State machine:
  - IDLE: busy=0, out_valid=0. start moves to RUN, loads x=0, q=-2^FRAC_W and r=0.
  - RUN: out_valid=1 and busy=1. On a transfer (out_valid && out_ready) with x < SCREEN_W-1, x increments and the accumulator advances; the new values are visible the next cycle.
  - On a transfer with out_last=1, go to IDLE; out_valid is low the next cycle.
- Latency and throughput:
  - Column 0 is presented the cycle after start.
  - Throughput is one column per cycle while out_ready is held high.
  - A full sweep takes SCREEN_W+1 cycles from start to IDLE.
- Back-pressure: while out_valid=1 and out_ready=0, out_col, out_camerax and out_last hold stable.
- start in RUN (including during a stall, or coincident with a transfer): abort and reload column 0 the next cycle; the pending output is dropped. start has priority over the transfer.
- start in IDLE coincident with nothing else: normal launch.
- out_ready while out_valid=0: ignored.
- Reset values (async assert, sync-deassert by the system): state=IDLE, busy=0, out_valid=0, out_col=0, out_camerax=0, out_last=0, q=0, r=0.
- Reset asserted mid-sweep aborts immediately; no output appears until the next start.
- Outputs are registered; there is no combinational path from out_ready or start to any output.

Test Plan:
- Defaults, start pulse, out_ready=1 -> 320 consecutive beats. Spot checks:
  - x=0: 0xFF00.
  - x=1: 0xFF01.
  - x=2: 0xFF03.
  - x=160: 0x0000.
  - x=319: 0x00FE with out_last=1.
  - busy falls the cycle after the last beat.
- Full-sweep compare against the floor formula, repeated for SCREEN_W=320/FRAC_W=8 and SCREEN_W=640/FRAC_W=12/DATA_W=20 -> zero mismatches.
- Random out_ready (50%) -> outputs stable while stalled, no skipped or duplicated columns, exactly SCREEN_W transfers.
- start asserted at x=100, both during a stall and coincident with a transfer -> next cycle out_col=0 and out_camerax=0xFF00, and column 100 is never transferred.
- rst_n low at x=50 -> out_valid and busy drop immediately, all outputs read 0; with no start afterwards, out_valid stays 0.
- SCREEN_W=2, FRAC_W=8 -> beats of -256 (x=0) and 0 (x=1, last).
